// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-bus memory bridge.
// The abort-data value is what a read returns when the optional timeout abandons it.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] ABORT_DATA      = 32'hDEADBEEF;
  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam logic [3:0]  READ_BE         = 4'hF;

endpackage

// File: rtl/mem_bridge_timer.sv
// REQ-state cycle counter for the bridge timeout (built only with MEM_BRIDGE_TIMEOUT_EN).
// o_expire fires during the TIMEOUT_CYCLES-th counted cycle so the FSM aborts on that edge.
module mem_bridge_timer
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= r_count + 16'd1;
    end
  end

  // r_count holds the number of already-elapsed REQ cycles, hence the -1.
  assign o_expire = i_count && (r_count == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bridge.sv
// Memory-stage bridge: turns a CPU load/store into a single bus request and stalls the pipeline.
// Optional bus timeout is enabled by defining MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  state_t      r_state;
  state_t      w_nextState;
  logic        w_isWrite;
  logic        w_reqIn;
  logic        w_ackTaken;
  logic        w_abort;
  logic        w_expire;
  logic        w_unused;
  logic [31:0] r_busAddr;
  logic [31:0] r_busWdata;
  logic [3:0]  r_busBe;
  logic        r_busWr;
  logic [31:0] r_rdata;

  // A store wins over a simultaneous load.
  assign w_isWrite = |cpu_we;
  assign w_reqIn   = w_isWrite || cpu_re;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic w_timerLoad;
  logic w_timerCount;
  logic r_err;

  assign w_timerLoad  = (r_state == ST_IDLE);
  assign w_timerCount = (r_state == ST_REQ) && !bus_ack;

  mem_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_timerLoad),
    .i_count (w_timerCount),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_expire = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    w_ackTaken  = 1'b0;
    w_abort     = 1'b0;
    bus_req     = 1'b0;
    cpu_stall   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cpu_stall = w_reqIn;
        if (w_reqIn) begin
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req   = 1'b1;
        cpu_stall = 1'b1;
        // An ack in the expiring cycle still counts as a completion.
        if (bus_ack) begin
          w_ackTaken  = 1'b1;
          w_nextState = ST_DONE;
        end else if (w_expire) begin
          w_abort     = 1'b1;
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_busBe    <= '0;
      r_busWr    <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == ST_IDLE) && w_reqIn) begin
        r_busAddr  <= {cpu_addr[31:2], 2'b00};
        r_busWdata <= cpu_wdata;
        r_busBe    <= w_isWrite ? cpu_we : READ_BE;
        r_busWr    <= w_isWrite;
      end
      if (w_ackTaken && !r_busWr) begin
        r_rdata <= bus_rdata;
      end else if (w_abort && !r_busWr) begin
        r_rdata <= ABORT_DATA;
      end
    end
  end

  assign bus_addr  = r_busAddr;
  assign bus_wdata = r_busWdata;
  assign bus_be    = r_busBe;
  assign bus_wr    = r_busWr;
  assign cpu_rdata = r_rdata;

  // Byte offset bits are dropped by word alignment; the parameter is only consumed by the timer.
  assign w_unused = ^{cpu_addr[1:0], (TIMEOUT_CYCLES == 0)};

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: directed access cases, random accesses against a
// transaction-level model, reset abandonment and (with MEM_BRIDGE_TIMEOUT_EN) the timeout abort.
module tb_mem_bridge;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expRdata    = 32'h0;
  logic        expErr      = 1'b0;

  mem_bridge #(
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .bus_req  (bus_req),
    .bus_wr   (bus_wr),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be   (bus_be),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete access starting at a negedge in IDLE; ackAt=0 means never acknowledge.
  task automatic applyStimulus(input logic [3:0] we, input logic re, input logic [31:0] addr,
                               input logic [31:0] wdata, input int ackAt, input logic [31:0] rdBus);
    int          stallCycles = 0;
    int          reqCycles   = 0;
    bit          finished    = 0;
    bit          isWrite     = (we != 4'h0);
    bit          aborted;
    logic [31:0] expAddr     = {addr[31:2], 2'b00};
    logic [3:0]  expBe       = isWrite ? we : 4'hF;
    int          expReq;
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    aborted   = (ackAt == 0);
    expReq    = aborted ? TB_TIMEOUT : ackAt;
    for (int c = 0; c < 64 && !finished; c++) begin
      #1;
      if (cpu_stall) stallCycles++;
      if (bus_req) begin
        reqCycles++;
        cpu_we = 4'h0;
        cpu_re = 1'b0;
        checkOutput("bus_addr", bus_addr, expAddr);
        checkOutput("bus_be", {28'h0, bus_be}, {28'h0, expBe});
        checkOutput("bus_wr", {31'h0, bus_wr}, {31'h0, isWrite});
        checkOutput("bus_wdata", bus_wdata, wdata);
        if (reqCycles == ackAt) begin
          bus_ack   = 1'b1;
          bus_rdata = rdBus;
        end
      end else if (reqCycles > 0) begin
        finished = 1;
        if (!isWrite) expRdata = aborted ? 32'hDEADBEEF : rdBus;
        if (aborted) expErr = 1'b1;
        checkOutput("done_stall", {31'h0, cpu_stall}, 32'h0);
        checkOutput("cpu_rdata", cpu_rdata, expRdata);
        checkOutput("err", {31'h0, err}, {31'h0, expErr});
      end
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
    checkOutput("access_completed", {31'h0, finished}, 32'h1);
    checkOutput("req_cycles", reqCycles, expReq);
    checkOutput("stall_cycles", stallCycles, expReq + 1);
  endtask

  initial begin
    int          ackAt;
    logic [3:0]  we;
    logic [31:0] keep;
    rst       = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_we    = '0;
    cpu_re    = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_bus_req", {31'h0, bus_req}, 32'h0);
    checkOutput("rst_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_be", {28'h0, bus_be}, 32'h0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] directed read, byte store, store+load");
    applyStimulus(4'h0, 1'b1, 32'h0000_1006, 32'h0, 3, 32'hCAFEF00D);
    checkOutput("read_data", cpu_rdata, 32'hCAFEF00D);
    applyStimulus(4'b0100, 1'b0, 32'h0000_2001, 32'h00AB_0000, 1, 32'h1111_2222);
    checkOutput("store_keeps_rdata", cpu_rdata, 32'hCAFEF00D);
    applyStimulus(4'hF, 1'b1, 32'h0000_3003, 32'h1234_5678, 2, 32'h3333_4444);
    checkOutput("both_is_write", cpu_rdata, 32'hCAFEF00D);

    $display("[TB] random accesses");
    for (int t = 0; t < 24; t++) begin
      ackAt = $urandom_range(1, 3);
      we    = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0:       applyStimulus(4'h0, 1'b1, $urandom, $urandom, ackAt, $urandom);
        1:       applyStimulus(we, 1'b0, $urandom, $urandom, ackAt, $urandom);
        default: applyStimulus(we, 1'b1, $urandom, $urandom, ackAt, $urandom);
      endcase
    end
    applyStimulus(4'h0, 1'b1, 32'h0000_4000, 32'h0, 2, 32'h5A5A_A5A5);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    $display("[TB] timeout abort and late ack");
    applyStimulus(4'h0, 1'b1, 32'h0000_5008, 32'h0, 0, 32'h0);
    checkOutput("abort_data", cpu_rdata, 32'hDEADBEEF);
    bus_ack   = 1'b1;
    bus_rdata = 32'h7777_8888;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checkOutput("late_ack_req", {31'h0, bus_req}, 32'h0);
    checkOutput("late_ack_rdata", cpu_rdata, 32'hDEADBEEF);
    checkOutput("err_sticky", {31'h0, err}, 32'h1);
    @(negedge clk);
    applyStimulus(4'h3, 1'b0, 32'h0000_6000, 32'hFFFF_0000, 1, 32'h0);
    checkOutput("err_still_set", {31'h0, err}, 32'h1);
`endif

    $display("[TB] reset during REQ");
    keep     = $urandom;
    cpu_re   = 1'b1;
    cpu_addr = keep;
    @(negedge clk);
    cpu_re = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("pre_reset_req", {31'h0, bus_req}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_bus_req", {31'h0, bus_req}, 32'h0);
    checkOutput("reset_stall", {31'h0, cpu_stall}, 32'h0);
    checkOutput("reset_bus_addr", bus_addr, 32'h0);
    checkOutput("reset_bus_wdata", bus_wdata, 32'h0);
    checkOutput("reset_bus_be", {28'h0, bus_be}, 32'h0);
    checkOutput("reset_bus_wr", {31'h0, bus_wr}, 32'h0);
    checkOutput("reset_rdata", cpu_rdata, 32'h0);
    checkOutput("reset_err", {31'h0, err}, 32'h0);
    rst      = 1'b1;
    expRdata = 32'h0;
    expErr   = 1'b0;
    @(negedge clk);
    applyStimulus(4'h0, 1'b1, 32'h0000_7004, 32'h0, 1, 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
